// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   sources. Source A is the main pipeline writeback. Source B is the
//   long-latency unit, such as multiply/divide or load return.
//   - Grants at most one source per cycle. A has priority.
//   - B is protected from starvation by a saturating denial counter.
//   - The register-file write is registered.
//   - A 32-entry busy scoreboard tracks destinations owned by in-flight
//     long-latency ops and flags read-after-write hazards to decode.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   a_valid/a_waddr/a_wdata       source A write request
//   a_ready                       A accepted this cycle (combinational)
//   b_valid/b_waddr/b_wdata       source B write request
//   b_ready                       B accepted this cycle (combinational)
//   iss_valid/iss_waddr           long-latency issue; marks dest busy
//   chk_raddr1/chk_raddr2         decode read addresses to check
//   hazard1/hazard2               read address is busy (combinational)
//   rf_we/rf_waddr/rf_wdata       registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_waddr,
  input  logic [4:0]  chk_raddr1,
  input  logic [4:0]  chk_raddr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [0:0] PRI_A = 1'b0;
  localparam logic [0:0] PRI_B = 1'b1;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(STARVE_LIMIT - 1);

  // Saturating increment for the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_busy;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_b_denied;
  logic [4:0]       w_wr_addr;
  logic [31:0]      w_wr_data;
  logic             w_wr_en;
  logic [31:0]      w_busy_set;
  logic [31:0]      w_busy_clr;

  // Grant selection. The priority source depends on state; the other
  // source still gets the port when the priority source is idle.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == PRI_B) begin
      if (b_valid)      w_grant_b = 1'b1;
      else if (a_valid) w_grant_a = 1'b1;
    end else begin
      if (a_valid)      w_grant_a = 1'b1;
      else if (b_valid) w_grant_b = 1'b1;
    end
  end

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign w_b_denied = b_valid && !w_grant_b;

  // Starvation tracking. Any visit to PRI_B resolves the starvation:
  // either B wins there, or B has gone idle. In both cases the count
  // restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PRI_A;
      r_cnt   <= '0;
    end else if (r_state == PRI_B) begin
      r_state <= PRI_A;
      r_cnt   <= '0;
    end else begin
      if (w_b_denied && (r_cnt == LIMIT_M1)) r_state <= PRI_B;
      else                                   r_state <= PRI_A;
      if (!b_valid || w_grant_b) r_cnt <= '0;
      else                       r_cnt <= sat_inc(r_cnt);
    end
  end

  // Write port. A transfer to x0 completes the handshake but never
  // writes. Address and data hold between writes.
  assign w_wr_addr = w_grant_b ? b_waddr : a_waddr;
  assign w_wr_data = w_grant_b ? b_wdata : a_wdata;
  assign w_wr_en   = (w_grant_a || w_grant_b) && (w_wr_addr != 5'd0);

  // ---- stage boundary: registered register-file write port ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr_en;
      if (w_wr_en) begin
        r_waddr <= w_wr_addr;
        r_wdata <= w_wr_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  // Busy scoreboard. A new issue to a register that B is retiring in the
  // same cycle belongs to the newer op, so the set is applied after the
  // clear. Bit 0 is forced clear because x0 is never busy.
  assign w_busy_set = iss_valid ? (32'd1 << iss_waddr) : 32'd0;
  assign w_busy_clr = w_grant_b ? (32'd1 << b_waddr)   : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
  end

  // Hazards read the registered busy state only. Same-cycle issue or
  // retire does not bypass into the check.
  assign hazard1 = r_busy[chk_raddr1];
  assign hazard2 = r_busy[chk_raddr2];

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources. Source A is the main pipeline writeback; source B is the long-latency unit (multiply/divide or load return). Selects at most one write per cycle, prevents starvation of B, and drives registered we/waddr/wdata into the register file. Keeps a 32-entry busy scoreboard for registers owned by in-flight long-latency operations and reports read-after-write hazards to the decode stage.

Parameters:
STARVE_LIMIT, 4, consecutive denied cycles of a valid B request before B is forced to win (legal range 1..15).
CNT_W, 4, width of the starvation counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
a_valid  in  1  source A write request.
a_waddr  in  5  source A destination register.
a_wdata  in  32  source A write data.
a_ready  out  1  A accepted this cycle (combinational).
b_valid  in  1  source B write request.
b_waddr  in  5  source B destination register.
b_wdata  in  32  source B write data.
b_ready  out  1  B accepted this cycle (combinational).
iss_valid  in  1  long-latency op issued; marks its destination busy.
iss_waddr  in  5  destination of the issued op.
chk_raddr1  in  5  decode read address 1.
chk_raddr2  in  5  decode read address 2.
hazard1  out  1  chk_raddr1 is busy (combinational).
hazard2  out  1  chk_raddr2 is busy (combinational).
rf_we  out  1  register-file write enable (registered).
rf_waddr  out  5  register-file write address (registered).
rf_wdata  out  32  register-file write data (registered).

Behaviour:
- Reset (async, high):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy[31:0]=0, starvation counter=0, state=PRI_A.
  - Mid-operation reset drops any in-flight grant; requesters re-present after reset falls.
- Transfer: occurs when valid && ready. Exactly one of a_ready/b_ready may be 1 in a cycle. ready is never 1 without the matching valid.
- FSM has two states:
  - PRI_A:
    - Grant A if a_valid; otherwise grant B if b_valid.
    - The counter increments (saturating) every cycle b_valid=1 and B is not granted.
    - The counter clears on a B transfer or when b_valid=0.
    - If B is denied while counter==STARVE_LIMIT-1, go to PRI_B next cycle.
  - PRI_B:
    - Grant B if b_valid (a_ready=0), then return to PRI_A with counter=0.
    - If b_valid=0, grant A if valid and return to PRI_A.
- Write port:
  - A transfer in cycle N produces rf_we=1 in cycle N+1, with rf_waddr/rf_wdata captured from the granted source.
  - With no transfer, rf_we=0 next cycle; rf_waddr/rf_wdata hold their last values.
  - A transfer with waddr==0 completes the handshake (ready=1), but rf_we stays 0.
- Scoreboard:
  - iss_valid && iss_waddr!=0 sets busy[iss_waddr] at the edge.
  - A B transfer clears busy[b_waddr].
  - Set and clear of the same register in the same cycle: set wins (newer issue owns the register).
  - A transfers never touch busy.
  - busy[0] is always 0.
- Hazards:
  - hazard1 = busy[chk_raddr1]; hazard2 = busy[chk_raddr2].
  - Combinational from current busy state; no bypass of same-cycle issue or clear.
- Simultaneous A and B to the same waddr: only the granted one writes; the other writes in a later cycle, so the later write wins.
- No buffering: a denied request must hold valid, waddr and wdata stable until ready.

Test Plan:
- Reset then idle -> rf_we=0, a_ready=b_ready=0, hazard1=hazard2=0 for all chk addresses; assert reset mid-transfer -> rf_we=0 next cycle, busy cleared.
- A only: a_valid=1, a_waddr=5, a_wdata=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Starvation: a_valid and b_valid held high, STARVE_LIMIT=4 -> A granted cycles 0-3, B granted cycle 4 (b_ready=1, a_ready=0), A granted cycle 5.
- Scoreboard:
  - iss_valid, iss_waddr=7 -> next cycle hazard1=1 with chk_raddr1=7.
  - B transfer with b_waddr=7 -> hazard1=0 the cycle after, rf_we=1 with rf_waddr=7.
- Set/clear collision: iss_waddr=9 and B transfer with b_waddr=9 in the same cycle -> busy[9] stays 1.
- Zero register:
  - A transfer with a_waddr=0 -> a_ready=1, rf_we stays 0.
  - iss_waddr=0 -> hazard with chk_raddr1=0 stays 0.
